// File: rtl/parity_pkg.sv
// Shared constants for the streaming parity generator/checker.
// Parity-mode encodings and the error-counter width.
package parity_pkg;

    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD  = 1;
    localparam int ERRCNT_W    = 16;

endpackage

// File: rtl/parity_stream_if.sv
// Beat-in / result-out handshake bundle for parity_stream.
// master drives beats and consumes results; slave is the block.
interface parity_stream_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_chk_en;
    logic             in_chk_bit;
    logic             out_valid;
    logic             out_ready;
    logic             out_parity;
    logic             out_error;
    logic [CNT_W-1:0] out_beats;

    modport master (
        output in_valid, in_data, in_last,
        output in_chk_en, in_chk_bit, out_ready,
        input  in_ready, out_valid, out_parity,
        input  out_error, out_beats
    );

    modport slave (
        input  in_valid, in_data, in_last,
        input  in_chk_en, in_chk_bit, out_ready,
        output in_ready, out_valid, out_parity,
        output out_error, out_beats
    );

endinterface

// File: rtl/parity_tree.sv
// Balanced XOR reduction of a WIDTH-bit word.
// Recursively halves the word so depth is ceil(log2(WIDTH)).
module parity_tree #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic             parity
);

    generate
        if (WIDTH == 1) begin : g_leaf
            assign parity = data[0];
        end else begin : g_node
            localparam int LO = WIDTH / 2;
            logic p_lo;
            logic p_hi;

            parity_tree #(.WIDTH(LO)) u_lo (
                .data   (data[LO-1:0]),
                .parity (p_lo)
            );

            parity_tree #(.WIDTH(WIDTH - LO)) u_hi (
                .data   (data[WIDTH-1:LO]),
                .parity (p_hi)
            );

            assign parity = p_lo ^ p_hi;
        end
    endgenerate

endmodule

// File: rtl/parity_stream.sv
// Streaming frame parity generator/checker with a one-deep result register.
// PARITY_STREAM_ERRCNT_EN adds a saturating 16-bit err_count output.
module parity_stream
    import parity_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ODD   = 0,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    parity_stream_if.slave      s
`ifdef PARITY_STREAM_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] err_count
`endif
);

    typedef struct packed {
        logic             parity;
        logic             error;
        logic [CNT_W-1:0] beats;
    } parity_result_t;

    localparam logic ODD_BIT = (ODD == PARITY_ODD);

    parity_result_t   res;
    parity_result_t   res_nxt;
    logic             res_valid;
    logic             acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             beat_par;
    logic             accept;
    logic             fire;

    parity_tree #(.WIDTH(WIDTH)) u_tree (
        .data   (s.in_data),
        .parity (beat_par)
    );

    assign s.in_ready = rst_n && (!res_valid || s.out_ready);
    assign accept     = s.in_valid && s.in_ready;
    assign fire       = res_valid && s.out_ready;
    assign cnt_inc    = (&cnt) ? cnt : cnt + CNT_W'(1);

    always_comb begin
        res_nxt        = '0;
        res_nxt.parity = acc ^ beat_par ^ ODD_BIT;
        res_nxt.error  = s.in_chk_en
                       && (res_nxt.parity != s.in_chk_bit);
        res_nxt.beats  = cnt_inc;
    end

    // A last beat accepted in the same cycle as a consume reloads
    // the register, so the later assignment keeps out_valid high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res       <= '0;
            res_valid <= 1'b0;
            acc       <= 1'b0;
            cnt       <= '0;
        end else begin
            if (fire)
                res_valid <= 1'b0;
            if (accept) begin
                if (s.in_last) begin
                    res       <= res_nxt;
                    res_valid <= 1'b1;
                    acc       <= 1'b0;
                    cnt       <= '0;
                end else begin
                    acc <= acc ^ beat_par;
                    cnt <= cnt_inc;
                end
            end
        end
    end

`ifdef PARITY_STREAM_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            err_count <= '0;
        else if (accept && s.in_last && res_nxt.error
                 && !(&err_count))
            err_count <= err_count + ERRCNT_W'(1);
    end
`endif

    assign s.out_valid  = res_valid;
    assign s.out_parity = res.parity;
    assign s.out_error  = res.error;
    assign s.out_beats  = res.beats;

endmodule

// File: doc/parity_stream.md
Name: parity_stream

Overview:
- Streaming parity generator/checker; parametrised successor of the 4-input combinational parity cell.
- Folds the parity of WIDTH-bit words over a multi-beat frame delimited by in_last.
- Emits one result per frame (parity bit, beat count, optional check error) through a one-deep valid/ready output register.
- Sits between a byte/word source and a link framer or checker.

Parameters:
- WIDTH, 8, data bits per beat (>=1).
- ODD, 0, 0 = even parity (XOR of all frame bits); 1 = odd parity (inverted XOR).
- CNT_W, 8, width of the frame beat counter (saturating).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  WIDTH  beat data.
- in_last  in  1  final beat of frame.
- in_chk_en  in  1  compare against in_chk_bit; sampled on last beat only.
- in_chk_bit  in  1  expected parity; sampled on last beat only.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_parity  out  1  frame parity per ODD.
- out_error  out  1  1 when in_chk_en was set and computed parity != in_chk_bit.
- out_beats  out  CNT_W  beats in frame, including last; saturates at 2^CNT_W-1.

Behaviour:
- Reset: on a clk edge with rst_n=0, clear acc, beat count, out_valid, out_parity, out_error and out_beats to 0. in_ready is forced 0 while rst_n=0.
- Reset mid-frame discards the partial frame; the first accepted beat after reset starts a new frame.
- in_ready = rst_n && (!out_valid || out_ready). This is combinational from out_ready; no combinational path from in_valid.
- Accepted non-last beat:
  - acc <= acc ^ (^in_data).
  - cnt <= sat(cnt+1).
- Accepted last beat:
  - p = acc ^ (^in_data) ^ ODD.
  - out_parity <= p.
  - out_error <= in_chk_en && (p != in_chk_bit).
  - out_beats <= sat(cnt+1).
  - out_valid <= 1.
  - acc <= 0, cnt <= 0.
- Latency: result is visible the cycle after the last beat is accepted. Throughput is 1 beat/cycle, including back-to-back single-beat frames, when out_ready is held 1.
- out_valid falls the cycle after out_valid && out_ready, unless a new last beat is accepted in the same cycle; then the new result loads and out_valid stays 1.
- Result fields are stable while out_valid && !out_ready. Input stalls (in_ready=0) and the partial frame accumulator is held.
- No beat is accepted with in_valid=0. in_data and in_last are don't-care then.
- Saturation: cnt stops at 2^CNT_W-1; parity keeps accumulating.
- Single-beat frame (in_last on first beat): out_beats=1, parity = ^in_data ^ ODD.

Optional Feature:
- Macro: PARITY_STREAM_ERRCNT_EN.
- Defined:
  - Adds output port err_count (16 bits).
  - Increments, saturating at 16'hFFFF, on every result load with out_error=1.
  - Cleared by reset.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package parity_pkg:
  - PARITY_EVEN=0 and PARITY_ODD=1 constants.
  - ERRCNT_W=16.
  - Typedef parity_result_t {parity, error, beats}; width taken from CNT_W at use site.
- One sub-module parity_tree: combinational WIDTH-input XOR reduction (balanced tree of 2-input xor primitives), instanced once on in_data.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_beats=0; after release, in_ready=1.
- Even frame, WIDTH=8, ODD=0, out_ready=1: beats 8'h01, 8'h03, 8'h80 (last) -> next cycle out_valid=1, out_parity=0, out_beats=3, out_error=0.
- Odd mode and check: ODD=1, single beat 8'hFF last, in_chk_en=1, in_chk_bit=0 -> out_parity=1, out_error=1 (err_count=1 with PARITY_STREAM_ERRCNT_EN).
- Backpressure: result pending with out_ready=0 for 4 cycles -> in_ready=0, fields stable; raise out_ready together with a new last beat 8'h07 -> out_valid stays 1, new out_parity=1, out_beats=1.
- Saturation: CNT_W=2, 6-beat frame of 8'h01 -> out_beats=3, out_parity=0.
- Mid-frame reset: 2 beats 8'h01, pulse rst_n=0 for 1 cycle, then single last beat 8'h00 -> out_parity=0, out_beats=1.
